// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Common data bus broadcaster. Execution results are queued in a
//   DEPTH-entry FIFO and broadcast one per cycle, in arrival order. A
//   64-entry scoreboard (busy) tracks which physical tags hold a value:
//   a broadcast sets the tag's bit, and a rename allocation clears it.
//   Tag 0 always reads as available, and results targeting tag 0 are
//   dropped.
//
//   Optional feature (macro CDB_BYPASS_EN): a result that arrives while
//   the FIFO is empty and STALL=0 is loaded straight into the broadcast
//   registers at the same edge and never occupies a FIFO entry.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   STALL                      freezes the broadcast (pop) side only
//   FLUSH                      empties the FIFO, marks every tag available
//   exe_valid/map/val/instr_num  result offered by execution
//   exe_ready                  FIFO has room (count < DEPTH)
//   rename_alloc/_map          tag allocated by rename (clears busy bit)
//   exe_broadcast/_map/_val    registered broadcast
//   complete_instr_num_rob     ROB number of the broadcast result
//   busy                       per-tag availability, 1 = value available
module cdb_broadcaster #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        exe_valid,
  input  logic [5:0]  exe_map,
  input  logic [31:0] exe_val,
  input  logic [31:0] exe_instr_num,
  output logic        exe_ready,
  input  logic        rename_alloc,
  input  logic [5:0]  rename_alloc_map,
  output logic        exe_broadcast,
  output logic [5:0]  exe_broadcast_map,
  output logic [31:0] exe_broadcast_val,
  output logic [31:0] complete_instr_num_rob,
  output logic [63:0] busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bc_q, bc_d;
  logic [5:0]    bc_map_q, bc_map_d;
  logic [31:0]   bc_val_q, bc_val_d;
  logic [31:0]   bc_num_q, bc_num_d;
  logic [63:0]   busy_q, busy_d;

  logic [5:0]    mem_map [DEPTH];
  logic [31:0]   mem_val [DEPTH];
  logic [31:0]   mem_num [DEPTH];

  logic push_ok, fifo_wr, pop, bypass;

  // Full is judged on the registered count, so a same-edge pop never
  // re-opens exe_ready while the FIFO is full.
  assign exe_ready = (count_q < DEPTH_C);
  assign push_ok   = exe_valid && exe_ready && !FLUSH && (exe_map != '0);
  assign pop       = !STALL && (count_q != '0);

`ifdef CDB_BYPASS_EN
  // Empty FIFO implies no pop is pending this edge.
  assign bypass = push_ok && (count_q == '0) && !STALL;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = push_ok && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    bc_d     = 1'b0;
    bc_map_d = '0;
    bc_val_d = '0;
    bc_num_d = '0;
    busy_d   = busy_q;
    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      busy_d   = '1;
    end else begin
      if (pop) begin
        bc_d     = 1'b1;
        bc_map_d = mem_map[rd_ptr_q];
        bc_val_d = mem_val[rd_ptr_q];
        bc_num_d = mem_num[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (bypass) begin
        bc_d     = 1'b1;
        bc_map_d = exe_map;
        bc_val_d = exe_val;
        bc_num_d = exe_instr_num;
      end
      if (fifo_wr) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(fifo_wr) - CW'(pop);
      // Set on broadcast first so a same-edge allocate of the tag wins.
      if (bc_d) begin
        busy_d[bc_map_d] = 1'b1;
      end
      if (rename_alloc && (rename_alloc_map != '0)) begin
        busy_d[rename_alloc_map] = 1'b0;
      end
    end
    busy_d[0] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      bc_q     <= 1'b0;
      bc_map_q <= '0;
      bc_val_q <= '0;
      bc_num_q <= '0;
      busy_q   <= '1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      bc_q     <= bc_d;
      bc_map_q <= bc_map_d;
      bc_val_q <= bc_val_d;
      bc_num_q <= bc_num_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_map[wr_ptr_q] <= exe_map;
      mem_val[wr_ptr_q] <= exe_val;
      mem_num[wr_ptr_q] <= exe_instr_num;
    end
  end

  assign exe_broadcast          = bc_q;
  assign exe_broadcast_map      = bc_map_q;
  assign exe_broadcast_val      = bc_val_q;
  assign complete_instr_num_rob = bc_num_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

  localparam int unsigned DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic        exe_valid;
  logic [5:0]  exe_map;
  logic [31:0] exe_val, exe_instr_num;
  logic        exe_ready;
  logic        rename_alloc;
  logic [5:0]  rename_alloc_map;
  logic        exe_broadcast;
  logic [5:0]  exe_broadcast_map;
  logic [31:0] exe_broadcast_val, complete_instr_num_rob;
  logic [63:0] busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cdb_broadcaster #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .exe_valid(exe_valid), .exe_map(exe_map), .exe_val(exe_val),
    .exe_instr_num(exe_instr_num), .exe_ready(exe_ready),
    .rename_alloc(rename_alloc), .rename_alloc_map(rename_alloc_map),
    .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
    .exe_broadcast_val(exe_broadcast_val),
    .complete_instr_num_rob(complete_instr_num_rob), .busy(busy)
  );

  // Reference model: a queue of pending results plus a scoreboard.
  typedef struct {
    logic [5:0]  map;
    logic [31:0] val;
    logic [31:0] num;
  } res_t;

  res_t        mq[$];
  logic        m_bc;
  logic [5:0]  m_map;
  logic [31:0] m_val, m_num;
  logic [63:0] m_busy;

  task automatic model_edge();
    res_t r;
    bit   popping, pushing, direct;
    if (RESET || FLUSH) begin
      mq.delete();
      m_bc = 0; m_map = 0; m_val = 0; m_num = 0;
      m_busy = '1;
      return;
    end
    popping = !STALL && (mq.size() > 0);
    pushing = exe_valid && (mq.size() < DEPTH) && (exe_map != 0);
    direct  = 0;
`ifdef CDB_BYPASS_EN
    direct = pushing && (mq.size() == 0) && !STALL;
`endif
    m_bc = 0; m_map = 0; m_val = 0; m_num = 0;
    if (popping) begin
      r = mq.pop_front();
      m_bc = 1; m_map = r.map; m_val = r.val; m_num = r.num;
    end else if (direct) begin
      m_bc = 1; m_map = exe_map; m_val = exe_val; m_num = exe_instr_num;
    end
    if (pushing && !direct) begin
      r.map = exe_map; r.val = exe_val; r.num = exe_instr_num;
      mq.push_back(r);
    end
    if (m_bc) m_busy[m_map] = 1'b1;
    if (rename_alloc && rename_alloc_map != 0) m_busy[rename_alloc_map] = 1'b0;
    m_busy[0] = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; FLUSH = 0; exe_valid = 0; exe_map = 0; exe_val = 0;
    exe_instr_num = 0; rename_alloc = 0; rename_alloc_map = 0;
  endtask

  task automatic test_reset();
    RESET = 1; idle_inputs();
    step(); step();
    RESET = 0;
    step();
    checks++; if (busy !== '1) begin errors++; $display("FAIL reset_busy got %h exp %h", busy, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL reset_bc got %b exp 0", exe_broadcast); end
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", exe_ready); end
    checks++; if (exe_broadcast_map !== 6'd0 || exe_broadcast_val !== 32'd0 || complete_instr_num_rob !== 32'd0) begin
      errors++; $display("FAIL reset_bc_data got %0d/%h/%0d exp 0/0/0", exe_broadcast_map, exe_broadcast_val, complete_instr_num_rob);
    end
  endtask

  task automatic test_basic();
    rename_alloc = 1; rename_alloc_map = 6'd5;
    step();
    rename_alloc = 0;
    checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL basic_alloc busy5 got %b exp 0", busy[5]); end
    exe_valid = 1; exe_map = 6'd5; exe_val = 32'hDEADBEEF; exe_instr_num = 32'd7;
    step();
    exe_valid = 0;
`ifndef CDB_BYPASS_EN
    checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL basic_early_bc got %b exp 0", exe_broadcast); end
    checks++; if (busy[5] !== 1'b0) begin errors++; $display("FAIL basic_early_busy got %b exp 0", busy[5]); end
    step();
`endif
    checks++; if (exe_broadcast !== 1'b1 || exe_broadcast_map !== 6'd5) begin
      errors++; $display("FAIL basic_bc got %b/%0d exp 1/5", exe_broadcast, exe_broadcast_map);
    end
    checks++; if (exe_broadcast_val !== 32'hDEADBEEF || complete_instr_num_rob !== 32'd7) begin
      errors++; $display("FAIL basic_data got %h/%0d exp deadbeef/7", exe_broadcast_val, complete_instr_num_rob);
    end
    checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy[5]); end
    step();
    checks++; if (exe_broadcast !== 1'b0 || exe_broadcast_map !== 6'd0) begin
      errors++; $display("FAIL basic_after got %b/%0d exp 0/0", exe_broadcast, exe_broadcast_map);
    end
  endtask

  task automatic test_stall_fill();
    logic [31:0] vals [DEPTH];
    STALL = 1;
    for (int i = 0; i < 9; i++) begin
      exe_valid = 1; exe_map = 6'(i + 1); exe_val = $urandom; exe_instr_num = 32'(100 + i);
      if (i < DEPTH) vals[i] = exe_val;
      checks++;
      if (exe_ready !== (i < DEPTH)) begin
        errors++; $display("FAIL fill_ready push %0d got %b exp %b", i, exe_ready, (i < DEPTH));
      end
      checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL fill_stalled_bc push %0d got %b exp 0", i, exe_broadcast); end
      step();
    end
    exe_valid = 0;
    STALL = 0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      checks++;
      if (exe_broadcast !== 1'b1 || exe_broadcast_map !== 6'(k + 1) || exe_broadcast_val !== vals[k]
          || complete_instr_num_rob !== 32'(100 + k)) begin
        errors++; $display("FAIL drain_order %0d got %b/%0d/%h/%0d exp 1/%0d/%h/%0d", k, exe_broadcast,
          exe_broadcast_map, exe_broadcast_val, complete_instr_num_rob, k + 1, vals[k], 100 + k);
      end
    end
    step();
    checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL drain_extra got %b exp 0", exe_broadcast); end
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", exe_ready); end
  endtask

  task automatic test_collision();
    exe_valid = 1; exe_map = 6'd12; exe_val = 32'h1234; exe_instr_num = 32'd12;
`ifdef CDB_BYPASS_EN
    rename_alloc = 1; rename_alloc_map = 6'd12;
    step();
`else
    step();
    exe_valid = 0;
    rename_alloc = 1; rename_alloc_map = 6'd12;
    step();
`endif
    exe_valid = 0; rename_alloc = 0;
    checks++; if (exe_broadcast !== 1'b1 || exe_broadcast_map !== 6'd12) begin
      errors++; $display("FAIL collide_bc got %b/%0d exp 1/12", exe_broadcast, exe_broadcast_map);
    end
    checks++; if (busy[12] !== 1'b0) begin errors++; $display("FAIL collide_busy got %b exp 0", busy[12]); end
    step();
  endtask

  task automatic test_flush();
    rename_alloc = 1; rename_alloc_map = 6'd20;
    step();
    rename_alloc = 0;
    STALL = 1;
    for (int i = 0; i < 3; i++) begin
      exe_valid = 1; exe_map = 6'(30 + i); exe_val = $urandom; exe_instr_num = 32'(i);
      step();
    end
    exe_valid = 0;
    checks++; if (busy[20] !== 1'b0) begin errors++; $display("FAIL flush_pre_busy got %b exp 0", busy[20]); end
    FLUSH = 1;
    step();
    FLUSH = 0; STALL = 0;
    checks++; if (busy !== '1) begin errors++; $display("FAIL flush_busy got %h exp all ones", busy); end
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", exe_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL flush_no_bc cyc %0d got %b exp 0", i, exe_broadcast); end
    end
  endtask

  task automatic test_map_zero();
    exe_valid = 1; exe_map = 6'd0; exe_val = 32'hABCD; exe_instr_num = 32'd1;
    step();
    exe_valid = 0;
    step();
    checks++; if (exe_broadcast !== 1'b0) begin errors++; $display("FAIL zero_no_bc got %b exp 0", exe_broadcast); end
    STALL = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      exe_valid = 1; exe_map = 6'(40 + i); exe_val = $urandom; exe_instr_num = 32'(i);
      step();
    end
    exe_map = 6'd0;
    step();
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL zero_count ready got %b exp 1", exe_ready); end
    exe_map = 6'd50;
    step();
    exe_valid = 0;
    checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL zero_full ready got %b exp 0", exe_ready); end
    FLUSH = 1;
    step();
    FLUSH = 0; STALL = 0;
  endtask

  task automatic test_random();
    bit exp_ready;
    for (int c = 0; c < 800; c++) begin
      RESET            = ($urandom_range(0, 99) == 0);
      FLUSH            = ($urandom_range(0, 39) == 0);
      STALL            = ($urandom_range(0, 2) == 0);
      exe_valid        = $urandom_range(0, 1);
      exe_map          = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 15));
      exe_val          = $urandom;
      exe_instr_num    = $urandom;
      rename_alloc     = ($urandom_range(0, 3) == 0);
      rename_alloc_map = 6'($urandom_range(0, 15));
      exp_ready = (mq.size() < DEPTH);
      checks++; if (exe_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, exe_ready, exp_ready); end
      step();
      checks++;
      if (exe_broadcast !== m_bc || exe_broadcast_map !== m_map || exe_broadcast_val !== m_val
          || complete_instr_num_rob !== m_num) begin
        errors++; $display("FAIL rand_bc cyc %0d got %b/%0d/%h/%h exp %b/%0d/%h/%h", c, exe_broadcast,
          exe_broadcast_map, exe_broadcast_val, complete_instr_num_rob, m_bc, m_map, m_val, m_num);
      end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %h exp %h", c, busy, m_busy); end
    end
    RESET = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_fill();
    test_collision();
    test_flush();
    test_map_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, result FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have these ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  pipeline stall; freezes the broadcast side.
- FLUSH  in  1  squash; empties the FIFO and marks all tags ready.
- exe_valid  in  1  execution result offered this cycle.
- exe_map  in  6  physical destination tag of the result.
- exe_val  in  32  result value.
- exe_instr_num  in  32  ROB sequence number of the result.
- exe_ready  out  1  FIFO can accept a result (combinational, equals count<DEPTH).
- rename_alloc  in  1  rename allocated a new physical tag.
- rename_alloc_map  in  6  tag being allocated.
- exe_broadcast  out  1  broadcast valid (registered).
- exe_broadcast_map  out  6  broadcast tag (registered).
- exe_broadcast_val  out  32  broadcast value (registered).
- complete_instr_num_rob  out  32  ROB number of the broadcast result (registered).
- busy  out  64  per-tag availability; 1 means the value is available (registered).

Function
REQ-003 A result SHALL be pushed at an edge where exe_valid=1, exe_ready=1 and FLUSH=0; exe_valid while exe_ready=0 SHALL be ignored, and the producer holds it.
REQ-004 Results with exe_map=0 SHALL be dropped, not pushed; exe_ready is unaffected.
REQ-005 When STALL=0 and the FIFO is non-empty, each edge SHALL pop the head into the broadcast registers with exe_broadcast=1; otherwise exe_broadcast SHALL be 0 and map/val/instr_num SHALL be 0.
REQ-006 Broadcasts SHALL leave in push order, one per cycle maximum.
REQ-007 Base latency: a result pushed at edge N SHALL appear on exe_broadcast after edge N+1 at the earliest.
REQ-008 Push and pop in the same edge SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-009 When full (count=DEPTH), exe_ready SHALL be 0 even if a pop occurs that edge.
REQ-010 busy[t] SHALL be set to 1 at the edge where t is broadcast, so busy and exe_broadcast are visible in the same cycle.
REQ-011 busy[rename_alloc_map] SHALL be cleared at an edge where rename_alloc=1 and rename_alloc_map!=0.
REQ-012 If an allocate and a broadcast target the same tag at one edge, the allocate (clear) SHALL win.
REQ-013 busy[0] SHALL always read 1.
REQ-014 STALL SHALL NOT block pushes or allocations.
REQ-015 FLUSH SHALL act at the next edge and take priority over everything except RESET:
- count and pointers go to 0.
- broadcast outputs go to 0.
- busy goes to all 1s.
- any same-edge push and allocate are discarded.

Reset
REQ-016 At an edge with RESET=1, the block SHALL force this state, overriding all other inputs:
- count=0; read/write pointers=0.
- exe_broadcast, exe_broadcast_map, exe_broadcast_val and complete_instr_num_rob all 0.
- busy=64'hFFFF_FFFF_FFFF_FFFF.
REQ-017 Reset mid-operation SHALL discard all queued results without broadcasting them.

Configuration
REQ-018 With macro CDB_BYPASS_EN defined, a push that arrives while the FIFO is empty, STALL=0 and no pop is pending SHALL load the broadcast registers directly at the same edge (1-cycle latency) and SHALL NOT occupy a FIFO entry.
REQ-019 Without CDB_BYPASS_EN, every result SHALL pass through the FIFO with the REQ-007 latency.
REQ-020 All other behaviour SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset then idle -> busy all 1s, exe_broadcast=0, exe_ready=1.
- rename_alloc map 5; push map 5 val 0xDEADBEEF num 7 at edge N -> busy[5]=0 until the broadcast; map 5/0xDEADBEEF/7 with busy[5]=1 after edge N+1 (edge N with CDB_BYPASS_EN).
- STALL=1 with 9 pushes at DEPTH=8 -> exe_ready=0 after 8; release STALL -> 8 broadcasts in push order over 8 consecutive cycles.
- Same edge: allocate map 12 and broadcast map 12 -> busy[12]=0.
- Fill 3 entries, FLUSH -> no broadcasts follow, busy all 1s, exe_ready=1.
- Push with exe_map=0 -> no broadcast, count unchanged.
